// File: rtl/vram_pkg.sv
// Shared display timing and framebuffer geometry for the VRAM arbiter.
package vram_pkg;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;

  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int ADDR_W  = 15;

  typedef logic [7:0] pixel_t;
endpackage

// File: rtl/vram_fetch_addr.sv
// Display slot detection and framebuffer address of the cell the scan needs next.
module vram_fetch_addr
  import vram_pkg::*;
(
  input  logic [9:0]        counter_x,
  input  logic [9:0]        counter_y,
  output logic              fetch,
  output logic [ADDR_W-1:0] fetch_addr
);
  logic       slot_line, slot_wrap, disp_slot;
  logic [9:0] next_y, src_y;
  logic [7:0] col, row;

  always_comb begin
    // Mid-line slots prefetch the next 4-pixel group; x=798 prefetches col 0 of the next line.
    slot_line  = (counter_x[1:0] == 2'd2) && (counter_x < 10'(H_VISIBLE - 2));
    slot_wrap  = (counter_x == 10'(H_TOTAL - 2));
    next_y     = (counter_y == 10'(V_TOTAL - 1)) ? 10'd0 : counter_y + 10'd1;
    src_y      = slot_wrap ? next_y : counter_y;
    col        = slot_wrap ? 8'd0 : counter_x[9:2] + 8'd1;
    row        = src_y[9:2];
    disp_slot  = slot_line | slot_wrap;
    fetch      = disp_slot && (src_y < 10'(V_VISIBLE));
    fetch_addr = (ADDR_W'(row) << 7) + (ADDR_W'(row) << 5) + ADDR_W'(col);
  end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM shared between fixed display fetch slots and a CPU req/ack port.
module vram_arbiter
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        counter_x,
  input  logic [9:0]        counter_y,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        pixel_color
);
  logic              fetch, fetch_d, in_range, rd_pend, rd_oor;
  logic [ADDR_W-1:0] fetch_addr;
  pixel_t            cur_pix;

  vram_fetch_addr u_fetch (
    .counter_x  (counter_x),
    .counter_y  (counter_y),
    .fetch      (fetch),
    .fetch_addr (fetch_addr)
  );

  // Display owns the RAM on its slots; every other cycle is the CPU's.
  assign in_range   = cpu_addr < ADDR_W'(FB_SIZE);
  assign cpu_ack    = cpu_req & ~fetch;
  assign ram_addr   = fetch ? fetch_addr : cpu_addr;
  assign ram_we     = cpu_ack & cpu_we & in_range;
  assign ram_wdata  = cpu_wdata;
  assign cpu_rvalid = rd_pend;
  assign cpu_rdata  = (rd_pend & ~rd_oor) ? ram_rdata : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_d     <= 1'b0;
      rd_pend     <= 1'b0;
      rd_oor      <= 1'b0;
      cur_pix     <= '0;
      pixel_color <= '0;
    end else begin
      fetch_d <= fetch;
      rd_pend <= cpu_ack & ~cpu_we;
      rd_oor  <= ~in_range;
      // RAM data for the slot fetch arrives at x=3 (mod 4), ready for the next group.
      if (counter_x[1:0] == 2'd3 && fetch_d) cur_pix <= ram_rdata;
      pixel_color <= (counter_x < 10'(H_VISIBLE) && counter_y < 10'(V_VISIBLE)) ? cur_pix : '0;
    end
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port, synchronous-read video RAM between the 640x480 display scan and the CPU port. The framebuffer is 160x120 cells, 8 bits each, and each cell is shown as a 4x4 pixel block. The block sits between the VGA timing generator (counter_x, counter_y) and the framebuffer RAM. It issues display fetches on fixed slots, grants every other cycle to the CPU via a req/ack handshake, and drives a registered pixel colour aligned with the registered sync outputs.

## Interface
- FB_W, 160: framebuffer width in cells
- FB_H, 120: framebuffer height in cells
- ADDR_W, 15: RAM address width (FB_W*FB_H = 19200 fits)
- clk  in  1  pixel clock, 25.175 MHz
- rst  in  1  synchronous, active-high reset
- counter_x  in  10  horizontal count from the timing generator, 0..799
- counter_y  in  10  vertical count, 0..524
- cpu_req  in  1  CPU access request, held until acked
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  linear cell address, row*FB_W+col
- cpu_wdata  in  8  write data
- cpu_ack  out  1  request accepted this cycle (combinational)
- cpu_rvalid  out  1  read data valid, one cycle after read ack
- cpu_rdata  out  8  read data
- ram_addr  out  ADDR_W  RAM address (combinational)
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, registered, valid the cycle after the address
- pixel_color  out  8  registered pixel, lags counter_x by one cycle

## Operation
- Display slot (disp_slot) is asserted when either condition holds:
  - counter_x[1:0]==2 and counter_x<638: target col = (counter_x>>2)+1, row = counter_y>>2.
  - counter_x==798: target col = 0, row = next_y>>2, where next_y = (counter_y==524) ? 0 : counter_y+1.
- A slot fetches only if its source line (counter_y, or next_y at x=798) is < 480. Otherwise the cycle is free.
- Fetching slot: ram_addr = row*FB_W+col, ram_we=0. Display has absolute priority.
- Non-fetching cycles go to the CPU: cpu_ack = cpu_req & ~fetch.
  - ram_addr = cpu_addr, ram_we = cpu_we & in_range, where in_range = cpu_addr < FB_W*FB_H.
- CPU write commits at the acked edge. No rvalid is generated for writes.
- CPU read: cpu_rvalid=1 on the next cycle. cpu_rdata = ram_rdata, or 0 if the address was out of range.
- Out-of-range address: still acked. A write is dropped and a read returns 0.
- Fetch capture: at the edge ending a cycle with counter_x[1:0]==3 that follows a fetch, cur_pix <= ram_rdata.
- Pixel output, every edge: pixel_color <= (counter_x<640 && counter_y<480) ? cur_pix : 0.
- No other state machine. A 1-bit pending flag tracks read return (rd_pend <= cpu_ack & ~cpu_we), plus an out-of-range flag for that read.

## Timing
- Reset values: pixel_color=0, cpu_rvalid=0, cpu_rdata=0, cur_pix=0, rd_pend=0. Reset does not gate cpu_ack, which follows cpu_req the same cycle.
- Display fetch to use: address at x≡2 (mod 4), data at x≡3, shown for x≡0..3 of the next group.
- Visible pixel (X,Y) appears on pixel_color in the cycle after counter_x==X.
- CPU read latency is exactly 1 cycle from ack. Worst-case CPU wait is 1 cycle, since slots are never adjacent.
- CPU bandwidth:
  - visible line: 3 of every 4 cycles;
  - blanking: all cycles except x=798 when next_y<480.
- Wrap: at counter_y=524, x=798 prefetches cell (0,0) for line 0.
- Reset mid-read: rvalid is suppressed. The CPU must re-request.

## Structure
- Package vram_pkg holds:
  - timing constants: H_VISIBLE=640, V_VISIBLE=480, H_TOTAL=800, V_TOTAL=525;
  - FB_W, FB_H, FB_SIZE, ADDR_W, and the pixel_t (8-bit) typedef.
- Sub-module vram_fetch_addr: combinational slot detect and row*160+col computation, as (row<<7)+(row<<5)+col. Keeps the arbiter free of multiplies.

## Test plan
- Reset then free-run one frame with no CPU traffic: pixel_color=0 throughout, no ram_we.
- CPU writes 0xA5 to address 161, cell (1,1): pixel_color=0xA5 for x=4..7, y=4..7 (one cycle lagged), 0 elsewhere.
- cpu_req held with a read at counter_x=2, y=0: cpu_ack=0 at x=2, ack at x=3, cpu_rvalid with data at x=4.
- Back-to-back reads across a line during blanking: ack every cycle except x=798. rdata matches the preloaded pattern.
- Write to address 19200: acked, ram_we=0. Read of 19200 returns 0 with rvalid.
- Fill the framebuffer with col^row, then check pixel_color at (0,0), (639,479), and the start of line 0 after the frame wrap.
